// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: one outstanding fetch, word-addressed RAM with a program-load port.
// Latency: response valid WAIT_CYCLES+1 cycles after request accept; data latched at accept.
// Backpressure: response held stable until resp_ready; req_ready only in IDLE without flush.
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        req_ok;
    logic        prog_ok;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] prog_idx;

    // Address legality: word aligned and inside the memory window.
    assign req_ok   = (req_addr[1:0] == 2'b00) && (req_addr < MEM_BYTES);
    assign prog_ok  = (prog_addr[1:0] == 2'b00) && (prog_addr < MEM_BYTES);
    assign req_idx  = req_addr[AW+1:2];
    assign prog_idx = prog_addr[AW+1:2];

    // Reset is folded in so the fetch side sees no acceptance while held in reset.
    assign req_ready = rst_n && (state_q == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: flush always wins over a pending handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response word captured at accept, so later program writes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else if (accept) begin
            resp_err  <= !req_ok;
            resp_data <= req_ok ? mem[req_idx] : NOP_INSN;
        end
    end

    // Program-load port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem[prog_idx] <= prog_data;
        end
    end

endmodule
